johnson_counter_param: RTL and testbench

JOHNSON_COUNTER_PARAM -- requirements
Module: johnson_counter_param

---
 rtl/jc_pkg.sv | 7 +
 rtl/jc_phase_decode.sv | 45 ++++
 rtl/johnson_counter_param.sv | 75 +++++++
 tb/tb_johnson_counter_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/jc_pkg.sv
// Shared constants for the parameterised Johnson counter.
// Direction encodings and default register width.
package jc_pkg;
   localparam logic JC_DIR_FWD       = 1'b0;
   localparam logic JC_DIR_REV       = 1'b1;
   localparam int   JC_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/jc_phase_decode.sv
// Decodes a Johnson code into its state index and a legality flag.
// A code is legal when it has at most one transition between adjacent bits.
module jc_phase_decode #(
   parameter int WIDTH = 4,
   parameter int PW    = $clog2(2*WIDTH)
) (
   input  logic [WIDTH-1:0] count_i,
   output logic [PW-1:0]    phase_o,
   output logic             legal_o
);
   localparam int            CW    = $clog2(WIDTH+1);
   // 2*WIDTH may not fit in PW bits; the modular subtraction below still
   // yields the right index because the result is always below 2*WIDTH.
   localparam logic [PW-1:0] TWO_W = PW'(2*WIDTH);

   logic [WIDTH-2:0] edge_w;
   logic [CW-1:0]    ones_w;
   logic [CW-1:0]    trans_w;

   generate
      for (genvar gi = 0; gi < WIDTH-1; gi++) begin : g_edge
         assign edge_w[gi] = count_i[gi] ^ count_i[gi+1];
      end
   endgenerate

   always_comb begin
      ones_w  = '0;
      trans_w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones_w = ones_w + CW'(count_i[i]);
      end
      for (int i = 0; i < WIDTH-1; i++) begin
         trans_w = trans_w + CW'(edge_w[i]);
      end
   end

   assign legal_o = (trans_w < CW'(2));

   always_comb begin
      phase_o = '0;
      if (legal_o) begin
         phase_o = count_i[WIDTH-1] ? (TWO_W - PW'(ones_w)) : PW'(ones_w);
      end
   end
endmodule

// File: rtl/johnson_counter_param.sv
// Bidirectional loadable Johnson counter with wrap pulse and phase output.
// Define JC_SELF_CORRECT_EN to flag illegal codes on err and clear them next edge.
module johnson_counter_param
   import jc_pkg::*;
#(
   parameter int WIDTH = JC_WIDTH_DEFAULT
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        dir,
   input  logic                        load,
   input  logic [WIDTH-1:0]            load_val,
   output logic [WIDTH-1:0]            count,
   output logic [$clog2(2*WIDTH)-1:0]  phase,
   output logic                        wrap,
   output logic                        err
);
   localparam int PW = $clog2(2*WIDTH);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic [PW-1:0]    phase_w;
   logic             legal_w;
   logic             correct_w;

   jc_phase_decode #(
      .WIDTH (WIDTH),
      .PW    (PW)
   ) u_decode (
      .count_i (count_q),
      .phase_o (phase_w),
      .legal_o (legal_w)
   );

`ifdef JC_SELF_CORRECT_EN
   assign correct_w = ~legal_w;
`else
   assign correct_w = 1'b0;
`endif

   // Wrap only fires from a legal code; stepping never maps illegal to legal.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (correct_w) begin
         count_d = '0;
      end else if (en) begin
         if (dir == JC_DIR_FWD) begin
            count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            wrap_d  = legal_w && (phase_w == PW'(2*WIDTH-1));
         end else begin
            count_d = {~count_q[0], count_q[WIDTH-1:1]};
            wrap_d  = legal_w && (phase_w == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign phase = phase_w;
   assign wrap  = wrap_q;
   assign err   = correct_w;
endmodule

// File: tb/tb_johnson_counter_param.sv
// Self-checking bench for johnson_counter_param (WIDTH=4 and WIDTH=8 instances).
// Reference model works on state indices into the Johnson sequence.
module tb_johnson_counter_param;
   import jc_pkg::*;

`ifdef JC_SELF_CORRECT_EN
   localparam bit SELF_CORR = 1'b1;
`else
   localparam bit SELF_CORR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       en4 = 0, dir4 = 0, load4 = 0;
   logic [3:0] lv4 = '0;
   logic [3:0] count4;
   logic [2:0] phase4;
   logic       wrap4, err4;

   logic       en8 = 0, dir8 = 0, load8 = 0;
   logic [7:0] lv8 = '0;
   logic [7:0] count8;
   logic [3:0] phase8;
   logic       wrap8, err8;

   johnson_counter_param #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .en(en4), .dir(dir4), .load(load4),
      .load_val(lv4), .count(count4), .phase(phase4), .wrap(wrap4), .err(err4)
   );

   johnson_counter_param #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .en(en8), .dir(dir8), .load(load8),
      .load_val(lv8), .count(count8), .phase(phase8), .wrap(wrap8), .err(err8)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int m_cnt   = 0;
   int m_wrap  = 0;

   typedef struct {
      bit         ld;
      logic [3:0] lv;
      bit         en;
      bit         dir;
      logic [3:0] c;
      int         ph;
      bit         wr;
   } vec_t;
   vec_t tbl[13];

   // k-th code of the Johnson sequence for a w-bit register
   function automatic int jc_code(int w, int k);
      int mask = (1 << w) - 1;
      if (k <= w) return (1 << k) - 1;
      return mask ^ ((1 << (k - w)) - 1);
   endfunction

   function automatic int jc_index(int w, int c);
      for (int k = 0; k < 2*w; k++) if (jc_code(w, k) == c) return k;
      return -1;
   endfunction

   task automatic check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(bit ld, int lv, bit e, bit d);
      int w = 4;
      int idx = jc_index(w, m_cnt);
      m_wrap = 0;
      if (ld) m_cnt = lv;
      else if (SELF_CORR && idx < 0) m_cnt = 0;
      else if (e) begin
         if (idx >= 0) begin
            if (d == JC_DIR_FWD) begin
               m_wrap = (idx == 2*w-1);
               m_cnt  = jc_code(w, (idx + 1) % (2*w));
            end else begin
               m_wrap = (idx == 0);
               m_cnt  = jc_code(w, (idx + 2*w - 1) % (2*w));
            end
         end else if (d == JC_DIR_FWD) begin
            m_cnt = ((m_cnt << 1) | (((~m_cnt) >> (w-1)) & 1)) & 15;
         end else begin
            m_cnt = (m_cnt >> 1) | (((~m_cnt) & 1) << (w-1));
         end
      end
   endtask

   task automatic drive4(bit ld, int lv, bit e, bit d);
      load4 = ld; lv4 = 4'(lv); en4 = e; dir4 = d;
      @(posedge clk);
      #1;
      model_edge(ld, lv, e, d);
   endtask

   task automatic check_model(string tag);
      int idx = jc_index(4, m_cnt);
      check({tag, "_count"}, int'(count4), m_cnt);
      check({tag, "_phase"}, int'(phase4), (idx >= 0) ? idx : 0);
      check({tag, "_wrap"},  int'(wrap4), m_wrap);
      check({tag, "_err"},   int'(err4), (SELF_CORR && idx < 0) ? 1 : 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wraps;
      // Scenario 1 / 2 / 3 vectors plus a hold row
      tbl[0]  = '{0, 4'h0, 1, 0, 4'b0001, 1, 0};
      tbl[1]  = '{0, 4'h0, 1, 0, 4'b0011, 2, 0};
      tbl[2]  = '{0, 4'h0, 1, 0, 4'b0111, 3, 0};
      tbl[3]  = '{0, 4'h0, 1, 0, 4'b1111, 4, 0};
      tbl[4]  = '{0, 4'h0, 1, 0, 4'b1110, 5, 0};
      tbl[5]  = '{0, 4'h0, 1, 0, 4'b1100, 6, 0};
      tbl[6]  = '{0, 4'h0, 1, 0, 4'b1000, 7, 0};
      tbl[7]  = '{0, 4'h0, 1, 0, 4'b0000, 0, 1};
      tbl[8]  = '{0, 4'h0, 1, 1, 4'b1000, 7, 1};
      tbl[9]  = '{0, 4'h0, 1, 1, 4'b1100, 6, 0};
      tbl[10] = '{1, 4'h7, 1, 0, 4'b0111, 3, 0};
      tbl[11] = '{0, 4'h0, 1, 0, 4'b1111, 4, 0};
      tbl[12] = '{0, 4'h0, 0, 0, 4'b1111, 4, 0};

      #3;
      check("rst_count", int'(count4), 0);
      check("rst_phase", int'(phase4), 0);
      check("rst_wrap",  int'(wrap4), 0);
      check("rst_err",   int'(err4), 0);
      check("rst_count8", int'(count8), 0);
      #7 reset = 1'b1;
      m_cnt = 0; m_wrap = 0;

      for (int i = 0; i < 13; i++) begin
         drive4(tbl[i].ld, int'(tbl[i].lv), tbl[i].en, tbl[i].dir);
         check($sformatf("vec%0d_count", i), int'(count4), int'(tbl[i].c));
         check($sformatf("vec%0d_phase", i), int'(phase4), tbl[i].ph);
         check($sformatf("vec%0d_wrap", i),  int'(wrap4), int'(tbl[i].wr));
         check($sformatf("vec%0d_err", i),   int'(err4), 0);
      end

      // Illegal code load and its follow-up edge
      drive4(1, 5, 0, 0);
      check("ill_count", int'(count4), 5);
      check("ill_phase", int'(phase4), 0);
      check("ill_err",   int'(err4), SELF_CORR ? 1 : 0);
      drive4(0, 0, 1, 0);
      check("ill_next_count", int'(count4), SELF_CORR ? 0 : 11);
      check("ill_next_phase", int'(phase4), 0);
      check("ill_next_err",   int'(err4), 0);

      // Asynchronous reset between edges with en=1 at 1110
      drive4(1, 14, 0, 0);
      check("pre_rst_count", int'(count4), 14);
      en4 = 1; load4 = 0;
      #3 reset = 1'b0;
      #1;
      check("arst_count", int'(count4), 0);
      check("arst_wrap",  int'(wrap4), 0);
      load4 = 1; lv4 = 4'h7;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check($sformatf("arst_hold%0d", i), int'(count4), 0);
      end
      load4 = 0;
      reset = 1'b1;
      m_cnt = 0; m_wrap = 0;
      drive4(0, 0, 1, 0);
      check("post_rst_count", int'(count4), 1);
      check("post_rst_phase", int'(phase4), 1);

      // Reset clears a live wrap pulse immediately
      drive4(1, 8, 0, 0);
      drive4(0, 0, 1, 0);
      check("wrap_before_rst", int'(wrap4), 1);
      #3 reset = 1'b0;
      #1;
      check("arst_wrap_clear", int'(wrap4), 0);
      #2 reset = 1'b1;
      m_cnt = 0; m_wrap = 0;

      for (int i = 0; i < 300; i++) begin
         bit ld, e, d;
         int lv;
         ld = ($urandom_range(0, 7) == 0);
         lv = $urandom_range(0, 15);
         e  = ($urandom_range(0, 3) != 0);
         d  = 1'($urandom_range(0, 1));
         drive4(ld, lv, e, d);
         check_model($sformatf("rnd%0d", i));
      end

      // WIDTH=8 period and hold behaviour
      en4 = 0; load4 = 0;
      en8 = 1; dir8 = 0; load8 = 0;
      wraps = 0;
      for (int i = 0; i < 35; i++) begin
         int exp;
         @(posedge clk); #1;
         exp = (i + 1) % 16;
         check($sformatf("w8_phase%0d", i), int'(phase8), exp);
         check($sformatf("w8_count%0d", i), int'(count8), jc_code(8, exp));
         check($sformatf("w8_wrap%0d", i),  int'(wrap8), (exp == 0) ? 1 : 0);
         wraps += int'(wrap8);
      end
      check("w8_wrap_total", wraps, 2);
      en8 = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("w8_hold_count%0d", i), int'(count8), 8'h07);
         check($sformatf("w8_hold_wrap%0d", i),  int'(wrap8), 0);
      end
      check("w8_err", int'(err8), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
